merge_cell: RTL and testbench
=============================

Name: merge_cell

Overview:
- 2-way merge stage sitting directly downstream of a pair of fifo2 instances (A and B) in the parallel merge-sort tree.
- Each FIFO holds one ascending sorted run of RUN_LEN words. The cell peeks both heads, pops the smaller, and emits one ascending run of 2*RUN_LEN words.
- The output feeds the wr_en/din of the next-level FIFO.
- Runs are processed back-to-back with no idle cycle between them.

Parameters:
- DATA_WIDTH, 32, key width; unsigned compare.
- LOG2_RUN_LEN, 2, input run length RUN_LEN = 2**LOG2_RUN_LEN words per side.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- a_dcmp  input  DATA_WIDTH  head word of FIFO A (unqualified peek).
- a_empty  input  1  FIFO A empty.
- a_rd_en  output  1  pop FIFO A this cycle (combinational).
- b_dcmp  input  DATA_WIDTH  head word of FIFO B.
- b_empty  input  1  FIFO B empty.
- b_rd_en  output  1  pop FIFO B this cycle (combinational).
- out_ready  input  1  downstream can take a word next cycle.
- out_data  output  DATA_WIDTH  merged word (registered).
- out_wr_en  output  1  out_data valid for one cycle (registered).
- run_done  output  1  one-cycle pulse coincident with the last word of a merged run.
- busy  output  1  high while any word of the current run has been consumed.

Behaviour:
- States:
  - MERGE: both sides still have words left in the current run.
  - DRAIN_A: B side exhausted; only A is popped.
  - DRAIN_B: A side exhausted; only B is popped.
- Counters cnt_a and cnt_b are LOG2_RUN_LEN+1 bits wide and count words popped from each side in the current run.
- Pop rules (at most one pop per cycle; a_rd_en and b_rd_en are never both 1):
  - MERGE: pop only when !a_empty && !b_empty && out_ready. Pop A if a_dcmp <= b_dcmp (ties take A, stable); otherwise pop B. If either side is empty, stall with no pop and stay in MERGE.
  - DRAIN_A: a_rd_en = !a_empty && out_ready.
  - DRAIN_B: b_rd_en = !b_empty && out_ready.
- Output register:
  - On a pop, at the next edge: out_data <= popped head, out_wr_en <= 1.
  - On no pop: out_wr_en <= 0 and out_data holds its value.
  - Latency from pop to out_wr_en is 1 cycle.
- Transitions:
  - MERGE -> DRAIN_B when a pop of A makes cnt_a == RUN_LEN.
  - MERGE -> DRAIN_A when a pop of B makes cnt_b == RUN_LEN.
  - DRAIN_x -> MERGE on the pop that completes 2*RUN_LEN words. On that edge both counters clear to 0 and run_done <= 1 in the same cycle as the final out_wr_en.
- Back-to-back runs: a new run may begin popping on the cycle after the final pop.
- busy = (cnt_a != 0) || (cnt_b != 0).
- Reset (reset == 0, asynchronous):
  - state = MERGE; cnt_a = cnt_b = 0; out_data = 0; out_wr_en = 0; run_done = 0.
  - a_rd_en and b_rd_en are forced to 0 while reset is asserted.
  - FIFO contents are not flushed by this cell; upstream FIFOs must share the same reset.
- Ordering assumption: input runs are ascending and each side supplies exactly RUN_LEN words per run. Out-of-order input is not detected.

Decomposition:
- Shared package `sort_pkg`:
  - state encoding constants for MERGE, DRAIN_A and DRAIN_B;
  - a data-width default;
  - a compare-function definition (unsigned <=, ties to A), reused by every tree level.
- One natural sub-module: merge_sel, a combinational head compare/select producing the pop side and the selected word. The FSM, counters and output register stay in merge_cell.

Test Plan:
- Interleaved: A = 1,3,5,7, B = 2,4,6,8, out_ready = 1 -> out_data 1..8 on 8 consecutive out_wr_en cycles; run_done on the word 8 cycle; rd_en alternates A,B,A,B,...
- Disjoint: A = 1,2,3,4, B = 5,6,7,8 -> four A pops, then DRAIN_B; output 1..8 with no gap cycles; cnt_a = 4 after cycle 4.
- Ties: A = 5,5,9,9, B = 5,9,9,9 -> pop order A,A,B,A,A,B,B,B; output 5,5,5,9,9,9,9,9.
- Starvation/back-pressure:
  - B empty for 3 cycles in MERGE with A non-empty -> no rd_en and no out_wr_en; merge then resumes correctly.
  - out_ready low for 2 cycles mid-run -> zero pops; no word lost or duplicated.
- Back-to-back plus reset:
  - Two runs loaded -> 16 words total with two run_done pulses.
  - Async reset asserted between edges mid-run -> out_wr_en, run_done, a_rd_en and b_rd_en go to 0 immediately; after release the cell is in MERGE with counters 0.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared definitions for every merge-tree level: FSM states, default key width
// and the head-compare rule.
package sort_pkg;

  typedef enum logic [1:0] {
    MERGE   = 2'd0,
    DRAIN_A = 2'd1,
    DRAIN_B = 2'd2
  } state_t;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned KEY_MAX_WIDTH  = 64;

  // Unsigned compare on zero-extended keys; ties favour A so the merge is stable.
  function automatic logic key_le(input logic [KEY_MAX_WIDTH-1:0] a,
                                  input logic [KEY_MAX_WIDTH-1:0] b);
    return a <= b;
  endfunction

endpackage

// File: rtl/merge_sel.sv
// Combinational head compare/select: decides which FIFO to pop this cycle and
// presents the word that will be registered.
module merge_sel
  import sort_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  state_t                state,
  input  logic [DATA_WIDTH-1:0] a_dcmp,
  input  logic                  a_empty,
  input  logic [DATA_WIDTH-1:0] b_dcmp,
  input  logic                  b_empty,
  input  logic                  out_ready,
  output logic                  a_pop,
  output logic                  b_pop,
  output logic [DATA_WIDTH-1:0] sel_data
);

  logic [KEY_MAX_WIDTH-1:0] a_ext;
  logic [KEY_MAX_WIDTH-1:0] b_ext;

  always_comb begin
    a_ext = '0;
    b_ext = '0;
    a_ext[DATA_WIDTH-1:0] = a_dcmp;
    b_ext[DATA_WIDTH-1:0] = b_dcmp;
    a_pop = 1'b0;
    b_pop = 1'b0;
    case (state)
      MERGE: begin
        if (!a_empty && !b_empty && out_ready) begin
          if (key_le(a_ext, b_ext)) a_pop = 1'b1;
          else                      b_pop = 1'b1;
        end
      end
      DRAIN_A: a_pop = !a_empty && out_ready;
      DRAIN_B: b_pop = !b_empty && out_ready;
      default: ;
    endcase
    sel_data = a_pop ? a_dcmp : b_dcmp;
  end

endmodule

// File: rtl/merge_cell.sv
// 2-way merge stage: pops the smaller FIFO head and emits one ascending run of
// 2*RUN_LEN words per pair of input runs, back-to-back.
module merge_cell
  import sort_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int unsigned LOG2_RUN_LEN = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] a_dcmp,
  input  logic                  a_empty,
  output logic                  a_rd_en,
  input  logic [DATA_WIDTH-1:0] b_dcmp,
  input  logic                  b_empty,
  output logic                  b_rd_en,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_wr_en,
  output logic                  run_done,
  output logic                  busy
);

  localparam int unsigned     CW      = LOG2_RUN_LEN + 1;
  localparam logic [CW-1:0]   RUN_LEN = CW'(2 ** LOG2_RUN_LEN);

  state_t                state;
  logic [CW-1:0]         cnt_a;
  logic [CW-1:0]         cnt_b;
  logic [CW-1:0]         cnt_a_inc;
  logic [CW-1:0]         cnt_b_inc;
  logic                  a_pop;
  logic                  b_pop;
  logic                  pop;
  logic [DATA_WIDTH-1:0] sel_data;

  merge_sel #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_sel (
    .state    (state),
    .a_dcmp   (a_dcmp),
    .a_empty  (a_empty),
    .b_dcmp   (b_dcmp),
    .b_empty  (b_empty),
    .out_ready(out_ready),
    .a_pop    (a_pop),
    .b_pop    (b_pop),
    .sel_data (sel_data)
  );

  // Pops are gated by reset so upstream FIFOs never lose a word during reset.
  assign a_rd_en   = reset && a_pop;
  assign b_rd_en   = reset && b_pop;
  assign pop       = a_rd_en || b_rd_en;
  assign cnt_a_inc = cnt_a + CW'(1);
  assign cnt_b_inc = cnt_b + CW'(1);
  assign busy      = (cnt_a != '0) || (cnt_b != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= MERGE;
      cnt_a     <= '0;
      cnt_b     <= '0;
      out_data  <= '0;
      out_wr_en <= 1'b0;
      run_done  <= 1'b0;
    end else begin
      out_wr_en <= pop;
      run_done  <= 1'b0;
      if (pop) out_data <= sel_data;
      case (state)
        MERGE: begin
          if (a_rd_en) begin
            cnt_a <= cnt_a_inc;
            if (cnt_a_inc == RUN_LEN) state <= DRAIN_B;
          end else if (b_rd_en) begin
            cnt_b <= cnt_b_inc;
            if (cnt_b_inc == RUN_LEN) state <= DRAIN_A;
          end
        end
        // In a drain state the other side is already full, so filling this
        // side completes the run and the next run can start immediately.
        DRAIN_A: begin
          if (a_rd_en) begin
            if (cnt_a_inc == RUN_LEN) begin
              cnt_a    <= '0;
              cnt_b    <= '0;
              state    <= MERGE;
              run_done <= 1'b1;
            end else begin
              cnt_a <= cnt_a_inc;
            end
          end
        end
        DRAIN_B: begin
          if (b_rd_en) begin
            if (cnt_b_inc == RUN_LEN) begin
              cnt_a    <= '0;
              cnt_b    <= '0;
              state    <= MERGE;
              run_done <= 1'b1;
            end else begin
              cnt_b <= cnt_b_inc;
            end
          end
        end
        default: state <= MERGE;
      endcase
    end
  end

endmodule

// File: tb/tb_merge_cell.sv
// Directed bench for merge_cell: two queue-style FIFO models feed the cell and
// every output word/pulse is checked against hand-computed vectors.
module tb_merge_cell;
  import sort_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] a_dcmp, b_dcmp, out_data;
  logic        a_empty, b_empty, a_rd_en, b_rd_en;
  logic        out_ready = 1'b1;
  logic        out_wr_en, run_done, busy;
  logic        b_hold = 1'b0;

  logic [31:0] mem_a [64];
  logic [31:0] mem_b [64];
  logic [5:0]  wr_a = '0, rd_a = '0, wr_b = '0, rd_b = '0;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int unsigned ed [16];
  bit          ea [16];

  always #5 clk = ~clk;

  merge_cell #(
    .DATA_WIDTH  (32),
    .LOG2_RUN_LEN(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .a_dcmp   (a_dcmp),
    .a_empty  (a_empty),
    .a_rd_en  (a_rd_en),
    .b_dcmp   (b_dcmp),
    .b_empty  (b_empty),
    .b_rd_en  (b_rd_en),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_wr_en(out_wr_en),
    .run_done (run_done),
    .busy     (busy)
  );

  // Upstream FIFO models: head is visible while non-empty, pop on rd_en,
  // flushed synchronously while reset is held.
  assign a_dcmp  = mem_a[rd_a];
  assign b_dcmp  = mem_b[rd_b];
  assign a_empty = (rd_a == wr_a);
  assign b_empty = b_hold || (rd_b == wr_b);

  always @(posedge clk) begin
    if (!reset) begin
      rd_a <= wr_a;
      rd_b <= wr_b;
    end else begin
      if (a_rd_en) rd_a <= rd_a + 6'd1;
      if (b_rd_en) rd_b <= rd_b + 6'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic load(input int unsigned a0, a1, a2, a3, b0, b1, b2, b3);
    mem_a[wr_a] = a0; wr_a = wr_a + 6'd1;
    mem_a[wr_a] = a1; wr_a = wr_a + 6'd1;
    mem_a[wr_a] = a2; wr_a = wr_a + 6'd1;
    mem_a[wr_a] = a3; wr_a = wr_a + 6'd1;
    mem_b[wr_b] = b0; wr_b = wr_b + 6'd1;
    mem_b[wr_b] = b1; wr_b = wr_b + 6'd1;
    mem_b[wr_b] = b2; wr_b = wr_b + 6'd1;
    mem_b[wr_b] = b3; wr_b = wr_b + 6'd1;
    #1;
  endtask

  // One pop per cycle expected over words lo..hi-1 of the ed/ea tables.
  task automatic run_check(input string tag, input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      chk($sformatf("%s a_rd_en[%0d]", tag, i), 32'(a_rd_en), 32'(ea[i]));
      chk($sformatf("%s b_rd_en[%0d]", tag, i), 32'(b_rd_en), 32'(!ea[i]));
      step();
      chk($sformatf("%s out_wr_en[%0d]", tag, i), 32'(out_wr_en), 32'd1);
      chk($sformatf("%s out_data[%0d]", tag, i), out_data, ed[i]);
      chk($sformatf("%s run_done[%0d]", tag, i), 32'(run_done), 32'((i % 8) == 7));
      chk($sformatf("%s busy[%0d]", tag, i), 32'(busy), 32'((i % 8) != 7));
    end
  endtask

  initial begin
    // Asynchronous reset with no clock edge
    #1 reset = 1'b0;
    #1;
    chk("rst out_wr_en", 32'(out_wr_en), 32'd0);
    chk("rst out_data", out_data, 32'd0);
    chk("rst run_done", 32'(run_done), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst state", 32'(dut.state), 32'(MERGE));
    step();
    step();
    reset = 1'b1;
    #1;

    // Interleaved
    load(1, 3, 5, 7, 2, 4, 6, 8);
    ed = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 0, 0, 0, 0, 0, 0, 0};
    ea = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_check("inter", 0, 8);

    // Disjoint: four A pops then drain B
    load(1, 2, 3, 4, 5, 6, 7, 8);
    ea = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_check("disj", 0, 4);
    chk("disj cnt_a", 32'(dut.cnt_a), 32'd4);
    chk("disj state", 32'(dut.state), 32'(DRAIN_B));
    run_check("disj", 4, 8);

    // Ties go to A
    load(5, 5, 9, 9, 5, 9, 9, 9);
    ed = '{5, 5, 5, 9, 9, 9, 9, 9, 0, 0, 0, 0, 0, 0, 0, 0};
    ea = '{1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_check("ties", 0, 8);

    // B starved for 3 cycles in MERGE
    b_hold = 1'b1;
    load(10, 20, 30, 40, 15, 25, 35, 45);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("starve a_rd_en[%0d]", i), 32'(a_rd_en), 32'd0);
      chk($sformatf("starve b_rd_en[%0d]", i), 32'(b_rd_en), 32'd0);
      step();
      chk($sformatf("starve out_wr_en[%0d]", i), 32'(out_wr_en), 32'd0);
      chk($sformatf("starve out_data[%0d]", i), out_data, 32'd9);
    end
    b_hold = 1'b0;
    #1;
    ed = '{10, 15, 20, 25, 30, 35, 40, 45, 0, 0, 0, 0, 0, 0, 0, 0};
    ea = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_check("starve", 0, 8);

    // out_ready low for 2 cycles mid-run
    load(2, 4, 6, 8, 1, 3, 5, 7);
    ed = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 0, 0, 0, 0, 0, 0, 0};
    ea = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    run_check("bp", 0, 3);
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("bp stall a_rd_en[%0d]", i), 32'(a_rd_en), 32'd0);
      chk($sformatf("bp stall b_rd_en[%0d]", i), 32'(b_rd_en), 32'd0);
      step();
      chk($sformatf("bp stall out_wr_en[%0d]", i), 32'(out_wr_en), 32'd0);
      chk($sformatf("bp stall out_data[%0d]", i), out_data, 32'd3);
    end
    out_ready = 1'b1;
    #1;
    run_check("bp", 3, 8);

    // Two runs back-to-back
    load(1, 3, 5, 7, 2, 4, 6, 8);
    load(20, 21, 22, 23, 10, 11, 12, 13);
    ed = '{1, 2, 3, 4, 5, 6, 7, 8, 10, 11, 12, 13, 20, 21, 22, 23};
    ea = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    run_check("b2b", 0, 16);
    step();
    chk("b2b idle out_wr_en", 32'(out_wr_en), 32'd0);

    // Asynchronous reset between edges mid-run
    load(1, 3, 5, 7, 2, 4, 6, 8);
    ed = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 0, 0, 0, 0, 0, 0, 0};
    ea = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_check("arst", 0, 3);
    #2 reset = 1'b0;
    #1;
    chk("arst out_wr_en", 32'(out_wr_en), 32'd0);
    chk("arst run_done", 32'(run_done), 32'd0);
    chk("arst a_rd_en", 32'(a_rd_en), 32'd0);
    chk("arst b_rd_en", 32'(b_rd_en), 32'd0);
    chk("arst out_data", out_data, 32'd0);
    chk("arst busy", 32'(busy), 32'd0);
    step();
    reset = 1'b1;
    #1;
    chk("arst post state", 32'(dut.state), 32'(MERGE));
    chk("arst post cnt_a", 32'(dut.cnt_a), 32'd0);
    chk("arst post cnt_b", 32'(dut.cnt_b), 32'd0);

    // Recovery run after reset
    load(4, 4, 6, 9, 3, 5, 7, 8);
    ed = '{3, 4, 4, 5, 6, 7, 8, 9, 0, 0, 0, 0, 0, 0, 0, 0};
    ea = '{0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    run_check("recov", 0, 8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
